// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sequential ALU: ALUOp/ALUctrl codes, funct3 selector,
// FSM state enum and a shift-decode helper.
package alu_seq_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_ARITH = 2'b10;

  localparam logic [2:0] CTRL_ADD  = 3'b000;
  localparam logic [2:0] CTRL_SUB  = 3'b001;
  localparam logic [2:0] CTRL_SLT  = 3'b010;
  localparam logic [2:0] CTRL_SLTU = 3'b011;  // branch compare meaning of 011
  localparam logic [2:0] CTRL_SLL  = 3'b011;  // arithmetic meaning of 011
  localparam logic [2:0] CTRL_XOR  = 3'b100;
  localparam logic [2:0] CTRL_SRL  = 3'b101;
  localparam logic [2:0] CTRL_OR   = 3'b110;
  localparam logic [2:0] CTRL_AND  = 3'b111;

  localparam logic [2:0] F3_SLTU = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_EXEC  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  function automatic logic is_shift(input logic [1:0] op, input logic [2:0] ctrl);
    return (op == ALUOP_ARITH) && ((ctrl == CTRL_SLL) || (ctrl == CTRL_SRL));
  endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// Bit-serial shifter: one position per step, SLL/SRL/SRA, with remaining-count.
module alu_shifter
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              left_i,
  input  logic              arith_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic              step_i,
  output logic [DATA_W-1:0] step_o,
  output logic              last_o
);

  logic [DATA_W-1:0]  data_q;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               left_q, arith_q;
  logic               fill;

  always_comb begin
    fill   = arith_q & data_q[DATA_W-1];
    step_o = left_q ? {data_q[DATA_W-2:0], 1'b0} : {fill, data_q[DATA_W-1:1]};
    last_o = (cnt_q == SHAMT_W'(1));
    cnt_d  = cnt_q;
    if (load_i)
      cnt_d = shamt_i;
    else if (step_i && (cnt_q != '0))
      cnt_d = cnt_q - SHAMT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      data_q  <= data_i;
      left_q  <= left_i;
      arith_q <= arith_i;
    end else if (step_i) begin
      data_q <= step_o;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops via EXEC, shifts bit-serially via alu_shifter,
// result held in DONE until the consumer takes it.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        ALUctrl,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUResult,
  output logic              Zero
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;
  logic [1:0]        op_q;
  logic [2:0]        ctrl_q, f3_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              accept, shift_load, shift_step, shift_last;
  logic [DATA_W-1:0] shift_val, exec_val;

  // Zero-shamt shift codes reach here through EXEC, so they pass SrcA unchanged.
  function automatic logic [DATA_W-1:0] alu_calc(input logic [1:0] op,
                                                 input logic [2:0] ctrl,
                                                 input logic [2:0] f3,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa, sb;
    logic lt_s, lt_u;
    sa   = a;
    sb   = b;
    lt_s = (sa < sb);
    lt_u = (a < b);
    alu_calc = '0;
    case (op)
      ALUOP_BR: begin
        case (ctrl)
          CTRL_SUB:  alu_calc = a - b;
          CTRL_SLT:  alu_calc = {{(DATA_W-1){1'b0}}, lt_s};
          CTRL_SLTU: alu_calc = {{(DATA_W-1){1'b0}}, lt_u};
          default:   alu_calc = '0;
        endcase
      end
      ALUOP_ARITH: begin
        case (ctrl)
          CTRL_ADD: alu_calc = a + b;
          CTRL_SUB: alu_calc = a - b;
          CTRL_SLT: alu_calc = {{(DATA_W-1){1'b0}}, (f3 == F3_SLTU) ? lt_u : lt_s};
          CTRL_XOR: alu_calc = a ^ b;
          CTRL_OR:  alu_calc = a | b;
          CTRL_AND: alu_calc = a & b;
          default:  alu_calc = a;
        endcase
      end
      default: alu_calc = a + b;  // ALUOP_MEM and the aliased 11 code
    endcase
  endfunction

  assign exec_val = alu_calc(op_q, ctrl_q, f3_q, a_q, b_q);

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    zero_d     = zero_q;
    accept     = 1'b0;
    shift_load = 1'b0;
    shift_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          if (is_shift(ALUOp, ALUctrl) && (SrcB[SHAMT_W-1:0] != '0)) begin
            shift_load = 1'b1;
            state_d    = S_SHIFT;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        res_d   = exec_val;
        zero_d  = (exec_val == '0);
        state_d = S_DONE;
      end
      S_SHIFT: begin
        shift_step = 1'b1;
        if (shift_last) begin
          res_d   = shift_val;
          zero_d  = (shift_val == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= ALUOp;
      ctrl_q <= ALUctrl;
      f3_q   <= funct3;
      a_q    <= SrcA;
      b_q    <= SrcB;
    end
  end

  alu_shifter u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (shift_load),
    .left_i  (ALUctrl == CTRL_SLL),
    .arith_i (funct7_5),
    .data_i  (SrcA),
    .shamt_i (SrcB[SHAMT_W-1:0]),
    .step_i  (shift_step),
    .step_o  (shift_val),
    .last_o  (shift_last)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign ALUResult = res_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against a behavioural reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  ALUOp;
  logic [2:0]  ALUctrl, funct3;
  logic        funct7_5;
  logic [31:0] SrcA, SrcB;
  logic        out_valid, out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  int n_vec = 0;
  int n_err = 0;

  alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOp     (ALUOp),
    .ALUctrl   (ALUctrl),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [2:0] ctrl,
                                          input logic [2:0] f3, input logic f7,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sr;
    int sh;
    sa = a;
    sb = b;
    sh = int'(b[4:0]);
    sr = sa >>> sh;
    if (op == 2'b01) begin
      if (ctrl == 3'd1) return a - b;
      if (ctrl == 3'd2) return (sa < sb) ? 32'd1 : 32'd0;
      if (ctrl == 3'd3) return (a < b) ? 32'd1 : 32'd0;
      return 32'd0;
    end
    if (op == 2'b10) begin
      case (ctrl)
        3'd0: return a + b;
        3'd1: return a - b;
        3'd2: return (f3 == 3'b011) ? ((a < b) ? 32'd1 : 32'd0) : ((sa < sb) ? 32'd1 : 32'd0);
        3'd3: return a << sh;
        3'd4: return a ^ b;
        3'd5: return f7 ? sr : (a >> sh);
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    return a + b;
  endfunction

  task automatic scramble_inputs();
    ALUOp    = 2'($urandom);
    ALUctrl  = 3'($urandom);
    funct3   = 3'($urandom);
    funct7_5 = 1'($urandom);
    SrcA     = $urandom;
    SrcB     = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] ctrl,
                        input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int lat, exp_lat, w;
    bit is_sh;
    exp     = ref_alu(op, ctrl, f3, f7, a, b);
    is_sh   = (op == 2'b10) && ((ctrl == 3'd3) || (ctrl == 3'd5)) && (b[4:0] != 5'd0);
    exp_lat = is_sh ? int'(b[4:0]) + 1 : 2;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, ":in_ready"}, {31'b0, in_ready}, 32'd1);
    ALUOp = op; ALUctrl = ctrl; funct3 = f3; funct7_5 = f7; SrcA = a; SrcB = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":result"}, ALUResult, exp);
    chk({tag, ":zero"}, {31'b0, Zero}, {31'b0, exp == 32'd0});
    if (!out_valid) return;
    in_valid = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      scramble_inputs();
      chk({tag, ":hold_valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, ":hold_result"}, ALUResult, exp);
      chk({tag, ":hold_in_ready"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, ":rel_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, ":rel_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, ":rel_result"}, ALUResult, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [2:0] f3;
    logic [31:0] b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUOp = '0; ALUctrl = '0; funct3 = '0; funct7_5 = 1'b0; SrcA = '0; SrcB = '0;
    #12;
    chk("reset:out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset:in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset:result", ALUResult, 32'd0);
    chk("reset:zero", {31'b0, Zero}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_5_7",   2'b10, 3'd0, 3'd0, 1'b0, 32'd5, 32'd7, 0);
    run_op("br_sub_eq", 2'b01, 3'd1, 3'd0, 1'b0, 32'h1234, 32'h1234, 0);
    run_op("br_slt",    2'b01, 3'd2, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("br_sltu",   2'b01, 3'd3, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("ar_sltu",   2'b10, 3'd2, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sll_31",    2'b10, 3'd3, 3'd1, 1'b0, 32'd1, 32'd31, 0);
    run_op("sra_4",     2'b10, 3'd5, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 0);
    run_op("srl_4",     2'b10, 3'd5, 3'd5, 1'b0, 32'h8000_0000, 32'd4, 0);
    run_op("sll_0",     2'b10, 3'd3, 3'd1, 1'b0, 32'hDEAD_BEEF, 32'h40, 1);
    run_op("op11_add",  2'b11, 3'd3, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("backpress", 2'b10, 3'd4, 3'd0, 1'b0, 32'hA5A5_0F0F, 32'h0FF0_1234, 5);

    // Reset in the middle of a 20-step shift.
    SrcA = 32'd1; SrcB = 32'd20; ALUOp = 2'b10; ALUctrl = 3'd3; funct7_5 = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst:out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst:in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst:result", ALUResult, 32'd0);
    chk("midrst:zero", {31'b0, Zero}, 32'd0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst:no_result", {31'b0, seen}, 32'd0);
    run_op("after_rst", 2'b10, 3'd3, 3'd0, 1'b0, 32'h0000_0003, 32'd5, 0);

    for (int i = 0; i < 250; i++) begin
      f3 = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op("rand", 2'($urandom), 3'($urandom), f3, 1'($urandom),
             ($urandom_range(0, 7) == 0) ? b : $urandom, b, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
